nios2_oci_dct_packer: RTL and testbench

Upstream feeder for the OCI trace test-bench stage. It packs 2-bit direct-control-transfer (DCT) codes from the Nios II instruction-trace path into a 30-bit shift buffer with a 4-bit entry count, which are presented live as dct_buffer/dct_count. It emits one frame per full buffer or explicit flush through a single-entry valid/ready output slot toward the trace FIFO. It detects and flags back-pressure overflow.

---
 rtl/nios2_oci_trace_pkg.sv | 31 +++
 rtl/nios2_oci_frame_slot.sv | 60 ++++++
 rtl/nios2_oci_dct_packer.sv | 164 ++++++++++++++++
 tb/tb_nios2_oci_dct_packer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/nios2_oci_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nios2_oci_trace_pkg
// Description : Shared types and constants for the Nios II OCI trace packers.
//               DCT code values, buffer/count/frame widths, the packed frame
//               layout {cnt, buffer}, and the output-slot state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package nios2_oci_trace_pkg;

    localparam logic [1:0] DCT_TAKEN     = 2'b10;
    localparam logic [1:0] DCT_NOT_TAKEN = 2'b11;

    localparam int DCT_BUF_W = 30;
    localparam int DCT_CNT_W = 4;
    localparam int FRAME_W   = DCT_CNT_W + DCT_BUF_W;

    // Frame layout on the wire: count in the top nibble, codes below it.
    typedef struct packed {
        logic [DCT_CNT_W-1:0] cnt;
        logic [DCT_BUF_W-1:0] buffer;
    } dct_frame_t;

    // Single-entry output slot occupancy.
    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage : nios2_oci_trace_pkg
`default_nettype wire

// File: rtl/nios2_oci_frame_slot.sv
`default_nettype none
// ============================================================================
// Module      : nios2_oci_frame_slot
// Description : Single-entry valid/ready holding register for trace frames.
//               A load captures i_load_data and marks the slot FULL; a
//               consumer handshake without a new load empties it. Data holds
//               its last value after draining. The caller only asserts i_load
//               when the slot is empty or being drained in the same cycle.
// Ports       : clk, reset_n (async, active low)
//               i_load, i_load_data[WIDTH]  - capture a new frame
//               i_ready                     - consumer accepts the frame
//               o_valid, o_data[WIDTH]      - slot contents
// Revision    : 1.0 - initial release
// ============================================================================
module nios2_oci_frame_slot
    import nios2_oci_trace_pkg::*;
#(
    parameter int WIDTH = FRAME_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    slot_state_e      r_state;
    slot_state_e      w_state_d;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_d;

    always_comb begin
        w_state_d = r_state;
        w_data_d  = r_data;
        if (i_load) begin
            // Covers both EMPTY->FULL and FULL->FULL on a same-cycle drain.
            w_state_d = SLOT_FULL;
            w_data_d  = i_load_data;
        end else if ((r_state == SLOT_FULL) && i_ready) begin
            w_state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SLOT_EMPTY;
            r_data  <= '0;
        end else begin
            r_state <= w_state_d;
            r_data  <= w_data_d;
        end
    end

    assign o_valid = (r_state == SLOT_FULL);
    assign o_data  = r_data;

endmodule : nios2_oci_frame_slot
`default_nettype wire

// File: rtl/nios2_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module      : nios2_oci_dct_packer
// Description : Packs 2-bit DCT codes into a 30-bit shift buffer (newest code
//               in [1:0]) with a live entry count, and emits {count, buffer}
//               frames through a single-entry valid/ready slot when the
//               buffer fills or a flush closes it. A flush that cannot be
//               served because the slot is busy is remembered (pend flush).
//               Codes arriving while the buffer is full and the slot is busy
//               are dropped and raise the sticky overflow flag.
// Ports       : clk, reset_n (async, active low)
//               dct_valid, dct_code[2], flush        - trace input
//               dct_buffer[30], dct_count[4]         - live buffer state
//               frame_valid, frame_ready, frame_data[34] - frame output
//               overflow                             - sticky loss flag
//               drop_count[8]                        - only with macro
// Options     : OCI_DCT_DROP_COUNT_EN adds drop_count, a saturating count of
//               dropped codes.
// Revision    : 1.0 - initial release
// ============================================================================
module nios2_oci_dct_packer #(
    parameter int MAX_ENTRIES = 15,
    parameter int FRAME_W     = nios2_oci_trace_pkg::FRAME_W
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      dct_valid,
    input  logic [1:0]                                dct_code,
    input  logic                                      flush,
    output logic [nios2_oci_trace_pkg::DCT_BUF_W-1:0] dct_buffer,
    output logic [nios2_oci_trace_pkg::DCT_CNT_W-1:0] dct_count,
    output logic                                      frame_valid,
    input  logic                                      frame_ready,
    output logic [FRAME_W-1:0]                        frame_data,
    output logic                                      overflow
`ifdef OCI_DCT_DROP_COUNT_EN
    ,
    output logic [7:0]                                drop_count
`endif
);

    import nios2_oci_trace_pkg::*;

    localparam logic [DCT_CNT_W-1:0] c_max = DCT_CNT_W'(MAX_ENTRIES);

    logic [DCT_BUF_W-1:0] r_buffer, w_buffer_d, w_buffer_n;
    logic [DCT_CNT_W-1:0] r_count,  w_count_d,  w_count_n;
    logic                 r_pend,   w_pend_d;
    logic                 r_overflow, w_overflow_d;

    logic       w_busy;
    logic       w_full;
    logic       w_drop;
    logic       w_emit_cond;
    logic       w_emit;
    dct_frame_t w_frame;

    // Slot cannot take a frame this cycle.
    assign w_busy = frame_valid && !frame_ready;
    assign w_full = (r_count == c_max);
    assign w_drop = dct_valid && w_full && w_busy;

    always_comb begin
        w_buffer_n     = r_buffer;
        w_count_n      = r_count;
        w_emit_cond    = 1'b0;
        w_emit         = 1'b0;
        w_frame.cnt    = r_count;
        w_frame.buffer = r_buffer;
        w_buffer_d     = r_buffer;
        w_count_d      = r_count;
        w_pend_d       = r_pend;

        if (w_full) begin
            // A complete frame is already held waiting for the slot. It
            // leaves as soon as the slot frees; a code arriving in that same
            // cycle starts the next buffer instead of overrunning the count,
            // and a flush alongside it is deferred to close that new buffer.
            w_emit_cond = 1'b1;
            w_emit      = !w_busy;
            if (w_emit) begin
                w_buffer_d = dct_valid ? {{(DCT_BUF_W-2){1'b0}}, dct_code} : '0;
                w_count_d  = dct_valid ? DCT_CNT_W'(1) : '0;
                w_pend_d   = dct_valid && flush;
            end
        end else begin
            if (dct_valid) begin
                w_buffer_n = {r_buffer[DCT_BUF_W-3:0], dct_code};
                w_count_n  = r_count + DCT_CNT_W'(1);
            end
            // Evaluated on post-append values so a same-cycle code is
            // included in a flushed frame.
            w_emit_cond    = (w_count_n == c_max) ||
                             ((flush || r_pend) && (w_count_n != '0));
            w_emit         = w_emit_cond && !w_busy;
            w_frame.cnt    = w_count_n;
            w_frame.buffer = w_buffer_n;
            if (w_emit) begin
                w_buffer_d = '0;
                w_count_d  = '0;
                w_pend_d   = 1'b0;
            end else begin
                w_buffer_d = w_buffer_n;
                w_count_d  = w_count_n;
                w_pend_d   = r_pend || (flush && (w_count_n != '0));
            end
        end
    end

    assign w_overflow_d = r_overflow || w_drop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buffer   <= '0;
            r_count    <= '0;
            r_pend     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_buffer   <= w_buffer_d;
            r_count    <= w_count_d;
            r_pend     <= w_pend_d;
            r_overflow <= w_overflow_d;
        end
    end

`ifdef OCI_DCT_DROP_COUNT_EN
    logic [7:0] r_drop_cnt, w_drop_cnt_d;

    always_comb begin
        w_drop_cnt_d = r_drop_cnt;
        if (w_drop && (r_drop_cnt != 8'hFF)) begin
            w_drop_cnt_d = r_drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_cnt_d;
        end
    end

    assign drop_count = r_drop_cnt;
`endif

    nios2_oci_frame_slot #(
        .WIDTH (FRAME_W)
    ) u_slot (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_emit),
        .i_load_data (FRAME_W'(w_frame)),
        .i_ready     (frame_ready),
        .o_valid     (frame_valid),
        .o_data      (frame_data)
    );

    assign dct_buffer = r_buffer;
    assign dct_count  = r_count;
    assign overflow   = r_overflow;

endmodule : nios2_oci_dct_packer
`default_nettype wire

// File: tb/tb_nios2_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios2_oci_dct_packer
// Description : Self-checking bench for nios2_oci_dct_packer. Expected frames
//               are queued as stimulus is driven and compared in order on
//               every frame handshake; live buffer/count/flags are checked
//               directly at chosen points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios2_oci_dct_packer;

    logic        clk;
    logic        reset_n;
    logic        dct_valid;
    logic [1:0]  dct_code;
    logic        flush;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frame_valid;
    logic        frame_ready;
    logic [33:0] frame_data;
    logic        overflow;
`ifdef OCI_DCT_DROP_COUNT_EN
    logic [7:0]  drop_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic [33:0] sb_q[$];

    nios2_oci_dct_packer u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .dct_valid   (dct_valid),
        .dct_code    (dct_code),
        .flush       (flush),
        .dct_buffer  (dct_buffer),
        .dct_count   (dct_count),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .overflow    (overflow)
`ifdef OCI_DCT_DROP_COUNT_EN
        ,
        .drop_count  (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle of stimulus: inputs held across one rising edge, then idle.
    task automatic drive(input logic v, input logic [1:0] c, input logic f);
        dct_valid = v;
        dct_code  = c;
        flush     = f;
        @(posedge clk);
        #1;
        dct_valid = 1'b0;
        dct_code  = 2'b00;
        flush     = 1'b0;
    endtask

    // Frame consumer: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (reset_n && frame_valid && frame_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
                chk("frame_data", 64'(frame_data), 64'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        dct_valid   = 1'b0;
        dct_code    = 2'b00;
        flush       = 1'b0;
        frame_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_buffer", 64'(dct_buffer), 64'd0);
        chk("rst_count", 64'(dct_count), 64'd0);
        chk("rst_valid", 64'(frame_valid), 64'd0);
        chk("rst_data", 64'(frame_data), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Three codes then a flush in the following cycle.
        drive(1'b1, 2'b10, 1'b0);
        drive(1'b1, 2'b11, 1'b0);
        drive(1'b1, 2'b10, 1'b0);
        chk("t1_count", 64'(dct_count), 64'd3);
        chk("t1_buffer", 64'(dct_buffer), 64'h2E);
        chk("t1_valid_pre", 64'(frame_valid), 64'd0);
        sb_q.push_back({4'd3, 30'h2E});
        drive(1'b0, 2'b00, 1'b1);
        chk("t1_valid_lat", 64'(frame_valid), 64'd1);
        chk("t1_count_clr", 64'(dct_count), 64'd0);
        drive(1'b0, 2'b00, 1'b0);
        chk("t1_drained", 64'(frame_valid), 64'd0);

        // Fifteen taken codes auto-emit; the sixteenth starts a new buffer.
        for (int i = 0; i < 14; i++) drive(1'b1, 2'b10, 1'b0);
        chk("t2_count14", 64'(dct_count), 64'd14);
        sb_q.push_back({4'd15, 30'h2AAAAAAA});
        drive(1'b1, 2'b10, 1'b0);
        chk("t2_valid", 64'(frame_valid), 64'd1);
        chk("t2_count_clr", 64'(dct_count), 64'd0);
        drive(1'b1, 2'b10, 1'b0);
        chk("t2_count16", 64'(dct_count), 64'd1);
        chk("t2_buffer16", 64'(dct_buffer), 64'h2);
        sb_q.push_back({4'd1, 30'h2});
        drive(1'b0, 2'b00, 1'b1);
        drive(1'b0, 2'b00, 1'b0);

        // Flush in the same cycle as the fifth code includes that code.
        for (int i = 0; i < 4; i++) drive(1'b1, 2'b11, 1'b0);
        sb_q.push_back({4'd5, 30'h3FE});
        drive(1'b1, 2'b10, 1'b1);
        chk("t3_valid", 64'(frame_valid), 64'd1);
        chk("t3_count_clr", 64'(dct_count), 64'd0);
        drive(1'b0, 2'b00, 1'b0);

        // Flush of an empty buffer produces nothing and leaves nothing pending.
        drive(1'b0, 2'b00, 1'b1);
        chk("t4_no_frame", 64'(frame_valid), 64'd0);
        drive(1'b1, 2'b10, 1'b0);
        chk("t4_no_pend", 64'(frame_valid), 64'd0);
        chk("t4_count", 64'(dct_count), 64'd1);
        sb_q.push_back({4'd1, 30'h2});
        drive(1'b0, 2'b00, 1'b1);
        drive(1'b0, 2'b00, 1'b0);
        drive(1'b0, 2'b00, 1'b0);

        // Back-pressure: hold a frame, fill the buffer, overrun it by two.
        frame_ready = 1'b0;
        sb_q.push_back({4'd1, 30'h3});
        drive(1'b1, 2'b11, 1'b1);
        chk("t5_valid_a", 64'(frame_valid), 64'd1);
        for (int i = 0; i < 14; i++) drive(1'b1, 2'b10, 1'b0);
        sb_q.push_back({4'd15, 30'h2AAAAAAA});
        drive(1'b1, 2'b10, 1'b0);
        chk("t5_count15", 64'(dct_count), 64'd15);
        chk("t5_hold_data", 64'(frame_data), 64'({4'd1, 30'h3}));
        chk("t5_overflow_pre", 64'(overflow), 64'd0);
        drive(1'b1, 2'b11, 1'b0);
        drive(1'b1, 2'b11, 1'b0);
        chk("t5_overflow", 64'(overflow), 64'd1);
        chk("t5_count_kept", 64'(dct_count), 64'd15);
        chk("t5_buffer_kept", 64'(dct_buffer), 64'h2AAAAAAA);
`ifdef OCI_DCT_DROP_COUNT_EN
        chk("t5_drop_count", 64'(drop_count), 64'd2);
`endif
        frame_ready = 1'b1;
        drive(1'b0, 2'b00, 1'b0);
        chk("t5_valid_b", 64'(frame_valid), 64'd1);
        chk("t5_data_b", 64'(frame_data), 64'({4'd15, 30'h2AAAAAAA}));
        chk("t5_count_clr", 64'(dct_count), 64'd0);
        drive(1'b0, 2'b00, 1'b0);
        chk("t5_drained", 64'(frame_valid), 64'd0);
        chk("t5_overflow_sticky", 64'(overflow), 64'd1);

        // Slot busy and flush at count 4: remembered until the slot frees.
        frame_ready = 1'b0;
        sb_q.push_back({4'd1, 30'h2});
        drive(1'b1, 2'b10, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 2'b11, 1'b0);
        drive(1'b0, 2'b00, 1'b1);
        chk("t6_count_held", 64'(dct_count), 64'd4);
        chk("t6_data_c", 64'(frame_data), 64'({4'd1, 30'h2}));
        drive(1'b0, 2'b00, 1'b0);
        chk("t6_count_wait", 64'(dct_count), 64'd4);
        chk("t6_valid_wait", 64'(frame_valid), 64'd1);
        sb_q.push_back({4'd4, 30'hFF});
        frame_ready = 1'b1;
        drive(1'b0, 2'b00, 1'b0);
        chk("t6_data_d", 64'(frame_data), 64'({4'd4, 30'hFF}));
        chk("t6_count_clr", 64'(dct_count), 64'd0);
        drive(1'b0, 2'b00, 1'b0);
        chk("t6_drained", 64'(frame_valid), 64'd0);

        chk("sb_leftover", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_nios2_oci_dct_packer
`default_nettype wire
